fourblock_color_ctrl: RTL and testbench
=======================================

# fourblock_color_ctrl

Controller for the four-tile VGA test pattern: owns the 12-bit colour of each 64×64 tile and shares write access between two requesters through a round-robin arbiter. Writes land in a shadow bank that is committed to the displayed bank only at frame start, so tiles never tear mid-frame. An optional timer rotates the tile colours every N frames. Sits between the pixel-coordinate generator and the VGA output registers, producing registered RGB per pixel.

## Interface
- `X0`, 100, left edge of tile grid (pixels)
- `Y0`, 50, top edge of tile grid (lines)
- `BLK`, 64, tile edge length
- `ROT_FRAMES`, 60, frames between rotations (≥1)
- `clk` in 1 pixel clock
- `rst_n` in 1 asynchronous active-low reset
- `x` in 10 current pixel column
- `y` in 10 current pixel line
- `frame_start` in 1 one-cycle pulse at start of vertical blanking
- `req` in 2 write request per requester; held until acked
- `wr_idx0`, `wr_idx1` in 2 target tile for requester 0/1
- `wr_color0`, `wr_color1` in 12 {R,G,B} nibbles for requester 0/1
- `rot_en` in 1 enable automatic rotation
- `ack` out 2 one-cycle grant/completion pulse per requester
- `pending` out 1 shadow bank differs from active bank
- `red`, `green`, `blue` out 4 registered pixel colour

## Operation
- Tiles: 0 = [X0,X0+BLK)×[Y0,Y0+BLK), 1 = right of 0, 2 = below 0, 3 = diagonal. Outside all tiles → 0xFFF (white).
- Reset value of both banks: tile0 F00, tile1 0F0, tile2 00F, tile3 FF0. Reset: `ack`=0, `pending`=0, RGB=0, arbiter pointer=0, frame counter=0.
- Arbiter: at most one write per cycle. Both requesting → grant the requester not granted last; pointer flips to the other after each grant. Single requester granted immediately.
- Grant: shadow[wr_idxN] ← wr_colorN, `ack[N]`=1 next cycle. Requester must drop or change `req[N]` the cycle `ack[N]` is seen; a still-high `req` is treated as a new request.
- `frame_start` cycle: no grant issued (arbiter stalls one cycle); active ← shadow; `pending` cleared next cycle.
- Rotation (`rot_en`=1): frame counter increments on each `frame_start`; when count = ROT_FRAMES−1 at `frame_start`, counter → 0 and both banks load rotated shadow: tile i ← shadow[(i+1) mod 4]. `rot_en`=0 holds counter at 0.
- `pending` = 1 whenever any shadow entry ≠ corresponding active entry, registered.

## Timing
- Pixel path: RGB valid 1 cycle after `x`/`y`; throughput 1 pixel/clock.
- Write: `req` sampled cycle T → shadow updated and `ack` high at T+1 (if T not a `frame_start` cycle; else T+1 grant, ack T+2).
- Commit: active bank changes at the clock edge ending the `frame_start` cycle; visible on RGB one cycle later.
- `pending` lags shadow/active changes by one cycle.
- `rst_n` low mid-operation: all state and outputs to reset values immediately; in-flight request lost, no `ack`.
- Same tile written by both requesters on consecutive cycles: later grant wins.

## Configuration
- `FOURBLOCK_ROTATE_EN` defined: frame counter and rotation logic present as above.
- Not defined: counter and rotation logic absent; `rot_en` ignored; commit is plain active ← shadow.

## Test plan
- Reset release, sweep x=100..227, y=50..177 → RGB F00/0F0/00F/FF0 per tile, FFF at (99,50) and (228,177), one-cycle latency.
- req0 writes tile2=0x5A5 at T → `ack[0]` at T+1, `pending`=1, tile2 still 00F until `frame_start`, then 5A5.
- req=2'b11 held for 4 grants → ack order 0,1,0,1; each ack one cycle apart.
- req0 asserted on `frame_start` cycle → no ack that cycle, ack one cycle later, write not in current commit.
- `FOURBLOCK_ROTATE_EN`, ROT_FRAMES=2, rot_en=1 → after 2nd `frame_start` tiles read 0F0/00F/FF0/F00.
- `rst_n` pulsed low during pending write → `ack` never asserted, banks back to reset colours, `pending`=0.

Source files
------------

// File: rtl/fourblock_color_ctrl.sv
// Four-tile colour controller: shadow/active colour banks, round-robin write arbiter, registered RGB.
// Optional frame-count rotation of the tile colours is built when FOURBLOCK_ROTATE_EN is defined.
module fourblock_color_ctrl #(
  parameter int X0         = 100,
  parameter int Y0         = 50,
  parameter int BLK        = 64,
  parameter int ROT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_start,
  input  logic [1:0]  req,
  input  logic [1:0]  wr_idx0,
  input  logic [1:0]  wr_idx1,
  input  logic [11:0] wr_color0,
  input  logic [11:0] wr_color1,
  input  logic        rot_en,
  output logic [1:0]  ack,
  output logic        pending,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  // Bank entry i holds tile i; reset colours red, green, blue, yellow.
  localparam logic [3:0][11:0] RST_BANK = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};

  localparam logic [10:0] XA = 11'(X0);
  localparam logic [10:0] XB = 11'(X0 + BLK);
  localparam logic [10:0] XC = 11'(X0 + 2 * BLK);
  localparam logic [10:0] YA = 11'(Y0);
  localparam logic [10:0] YB = 11'(Y0 + BLK);
  localparam logic [10:0] YC = 11'(Y0 + 2 * BLK);

  logic [3:0][11:0] shadow_q, shadow_d;
  logic [3:0][11:0] active_q, active_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       ack_q, ack_d;
  logic             pending_q, pending_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             grant0, grant1;

`ifdef FOURBLOCK_ROTATE_EN
  localparam int CW = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROT_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_rot_en;
  assign unused_rot_en = rot_en;
`endif

  // Arbiter: stalls on frame_start so a commit never races a shadow write.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!frame_start) begin
      if (req == 2'b11) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = req[0];
        grant1 = req[1];
      end
    end
    ptr_d = ptr_q;
    if (grant0) ptr_d = 1'b1;
    if (grant1) ptr_d = 1'b0;
    ack_d = {grant1, grant0};
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (grant0) shadow_d[wr_idx0] = wr_color0;
    if (grant1) shadow_d[wr_idx1] = wr_color1;
`ifdef FOURBLOCK_ROTATE_EN
    cnt_d = cnt_q;
    if (frame_start) begin
      if (rot_en && (cnt_q == LAST)) begin
        cnt_d    = '0;
        shadow_d = {shadow_q[0], shadow_q[3], shadow_q[2], shadow_q[1]};
        active_d = {shadow_q[0], shadow_q[3], shadow_q[2], shadow_q[1]};
      end else begin
        cnt_d    = cnt_q + 1'b1;
        active_d = shadow_q;
      end
    end
    if (!rot_en) cnt_d = '0;
`else
    if (frame_start) active_d = shadow_q;
`endif
    pending_d = (shadow_q != active_q);
  end

  always_comb begin
    logic [10:0] xo, yo;
    logic        in_x0, in_x1, in_y0, in_y1;
    xo    = {1'b0, x};
    yo    = {1'b0, y};
    in_x0 = (xo >= XA) && (xo < XB);
    in_x1 = (xo >= XB) && (xo < XC);
    in_y0 = (yo >= YA) && (yo < YB);
    in_y1 = (yo >= YB) && (yo < YC);
    rgb_d = 12'hFFF;
    if (in_x0 && in_y0) rgb_d = active_q[0];
    if (in_x1 && in_y0) rgb_d = active_q[1];
    if (in_x0 && in_y1) rgb_d = active_q[2];
    if (in_x1 && in_y1) rgb_d = active_q[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= RST_BANK;
      active_q  <= RST_BANK;
      ptr_q     <= 1'b0;
      ack_q     <= 2'b00;
      pending_q <= 1'b0;
      rgb_q     <= 12'h000;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
      rgb_q     <= rgb_d;
    end
  end

  assign ack     = ack_q;
  assign pending = pending_q;
  assign red     = rgb_q[11:8];
  assign green   = rgb_q[7:4];
  assign blue    = rgb_q[3:0];

endmodule

// File: tb/tb_fourblock_color_ctrl.sv
// Directed bench for fourblock_color_ctrl: pixel map, writes, arbitration, commit timing, reset.
module tb_fourblock_color_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        frame_start = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  wr_idx0 = '0, wr_idx1 = '0;
  logic [11:0] wr_color0 = '0, wr_color1 = '0;
  logic        rot_en = 1'b0;
  logic [1:0]  ack;
  logic        pending;
  logic [3:0]  red, green, blue;

  int checks = 0;
  int failures = 0;
  logic [11:0] bank [4];

  fourblock_color_ctrl #(.X0(100), .Y0(50), .BLK(64), .ROT_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_start(frame_start),
    .req(req), .wr_idx0(wr_idx0), .wr_idx1(wr_idx1),
    .wr_color0(wr_color0), .wr_color1(wr_color1), .rot_en(rot_en),
    .ack(ack), .pending(pending), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_color(input int px, input int py);
    logic [11:0] c;
    c = 12'hFFF;
    if (px >= 100 && px < 164 && py >= 50 && py < 114) c = bank[0];
    if (px >= 164 && px < 228 && py >= 50 && py < 114) c = bank[1];
    if (px >= 100 && px < 164 && py >= 114 && py < 178) c = bank[2];
    if (px >= 164 && px < 228 && py >= 114 && py < 178) c = bank[3];
    return c;
  endfunction

  task automatic set_reset_bank();
    bank[0] = 12'hF00; bank[1] = 12'h0F0; bank[2] = 12'h00F; bank[3] = 12'hFF0;
  endtask

  task automatic pix(input string tag, input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    tick();
    check(tag, {red, green, blue}, exp_color(px, py));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00;
    frame_start = 1'b0;
    rot_en = 1'b0;
    tick();
    rst_n = 1'b1;
    set_reset_bank();
  endtask

  initial begin
    int ylist [6];
    int xlist [6];
    ylist = '{49, 50, 113, 114, 177, 178};
    xlist = '{99, 100, 163, 164, 227, 228};
    set_reset_bank();

    // Reset state
    tick();
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_ack", {10'd0, ack}, 12'h000);
    check("rst_pending", {11'd0, pending}, 12'h000);
    rst_n = 1'b1;

    // Pixel map sweep across tile boundaries
    pix("edge_99_50", 99, 50);
    pix("edge_228_177", 228, 177);
    for (int i = 0; i < 6; i++)
      for (int px = 98; px <= 230; px++) pix("sweep_row", px, ylist[i]);
    for (int i = 0; i < 6; i++)
      for (int py = 48; py <= 180; py++) pix("sweep_col", xlist[i], py);

    // One-cycle latency: output holds old colour until the next edge
    pix("lat_a", 100, 50);
    x = 10'd227; y = 10'd177;
    #2;
    check("lat_hold", {red, green, blue}, 12'hF00);
    tick();
    check("lat_new", {red, green, blue}, 12'hFF0);

    // Single write to tile2, commit on frame_start
    x = 10'd120; y = 10'd130;
    req = 2'b01; wr_idx0 = 2'd2; wr_color0 = 12'h5A5;
    tick();
    check("wr_ack", {10'd0, ack}, 12'h001);
    check("wr_pre_commit", {red, green, blue}, 12'h00F);
    req = 2'b00;
    tick();
    check("wr_ack_drop", {10'd0, ack}, 12'h000);
    check("wr_pending", {11'd0, pending}, 12'h001);
    check("wr_still_old", {red, green, blue}, 12'h00F);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("commit_edge_old", {red, green, blue}, 12'h00F);
    tick();
    check("commit_visible", {red, green, blue}, 12'h5A5);
    check("commit_pending_clr", {11'd0, pending}, 12'h000);

    // Round-robin with both requesters held
    do_reset();
    req = 2'b11;
    wr_idx0 = 2'd0; wr_color0 = 12'h111;
    wr_idx1 = 2'd0; wr_color1 = 12'h222;
    tick(); check("rr_g1", {10'd0, ack}, 12'h001);
    tick(); check("rr_g2", {10'd0, ack}, 12'h002);
    tick(); check("rr_g3", {10'd0, ack}, 12'h001);
    tick(); check("rr_g4", {10'd0, ack}, 12'h002);
    req = 2'b00;
    tick(); check("rr_idle", {10'd0, ack}, 12'h000);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bank[0] = 12'h222;
    pix("rr_last_wins", 110, 60);

    // Request on frame_start: stalled one cycle, missed by this commit
    do_reset();
    x = 10'd200; y = 10'd150;
    req = 2'b01; wr_idx0 = 2'd3; wr_color0 = 12'hABC;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs_no_ack", {10'd0, ack}, 12'h000);
    tick();
    check("fs_late_ack", {10'd0, ack}, 12'h001);
    req = 2'b00;
    check("fs_not_committed", {red, green, blue}, 12'hFF0);
    tick();
    check("fs_pending", {11'd0, pending}, 12'h001);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("fs_next_commit", {red, green, blue}, 12'hABC);

    // Reset during an in-flight write
    do_reset();
    req = 2'b01; wr_idx0 = 2'd1; wr_color0 = 12'h777;
    x = 10'd170; y = 10'd60;
    #2;
    rst_n = 1'b0;
    tick();
    check("rst_mid_ack", {10'd0, ack}, 12'h000);
    check("rst_mid_rgb", {red, green, blue}, 12'h000);
    req = 2'b00;
    rst_n = 1'b1;
    tick();
    check("rst_mid_ack2", {10'd0, ack}, 12'h000);
    check("rst_mid_pending", {11'd0, pending}, 12'h000);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    set_reset_bank();
    pix("rst_mid_tile1", 170, 60);

    // Rotation after two frames (absent in the default build: colours unchanged)
    do_reset();
    rot_en = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
`ifdef FOURBLOCK_ROTATE_EN
    bank[0] = 12'h0F0; bank[1] = 12'h00F; bank[2] = 12'hFF0; bank[3] = 12'hF00;
`endif
    pix("rot_t0", 100, 50);
    pix("rot_t1", 200, 50);
    pix("rot_t2", 100, 150);
    pix("rot_t3", 200, 150);
    pix("rot_out", 300, 300);
    rot_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
